// File: rtl/tt_um_marxkar_progseqdet.sv
// tt_um_marxkar_progseqdet: strobe-sampled serial sequence detector with run-time pattern/length, overlap modes and saturating match counter
module tt_um_marxkar_progseqdet #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 5
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  typedef enum logic [1:0] {UNCFG, FILL, HUNT} state_t;
  state_t               r_state, w_state_n;
  logic [MAX_LEN-1:0]   r_p, w_p_n, r_h, w_h_n, w_h, w_mask;
  logic [3:0]           r_l, w_l_n, r_f, w_f_n, w_len;
  logic [CNT_W-1:0]     r_c, w_c_n;
  logic                 r_m, w_m_n, r_hit, w_hit_n, w_match, w_done;
  assign w_h     = {r_h[MAX_LEN-2:0], ui_in[0]};
  assign w_mask  = {MAX_LEN{1'b1}} >> (4'(MAX_LEN) - r_l);
  assign w_match = ((w_h ^ r_p) & w_mask) == '0;
  assign w_done  = (r_state == HUNT) || (r_f + 4'd1 == r_l);
  assign w_len   = {1'b0, ui_in[6:4]} + 4'd1;
  always_comb begin
    w_state_n = r_state;
    w_p_n     = r_p;
    w_l_n     = r_l;
    w_m_n     = r_m;
    w_h_n     = r_h;
    w_f_n     = r_f;
    w_c_n     = r_c;
    w_hit_n   = 1'b0;
    if (ena) begin
      if (ui_in[7]) begin
        w_p_n     = uio_in[MAX_LEN-1:0];
        w_l_n     = (w_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : w_len;
        w_m_n     = ui_in[2];
        w_h_n     = '0;
        w_f_n     = '0;
        w_state_n = FILL;
      end else begin
        if (ui_in[3]) w_c_n = '0;
        if (ui_in[1] && r_state != UNCFG) begin
          w_h_n = w_h;
          if (r_state == FILL) begin
            w_f_n     = r_f + 4'd1;
            w_state_n = w_done ? HUNT : FILL;
          end
          // non-overlap restarts the fill so matched bits are never reused
          if (w_done && w_match) begin
            w_hit_n = 1'b1;
            if (!ui_in[3] && !(&r_c)) w_c_n = r_c + CNT_W'(1);
            if (r_m) begin
              w_f_n     = '0;
              w_state_n = FILL;
            end
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= UNCFG;
      r_p     <= '0;
      r_l     <= 4'd1;
      r_m     <= 1'b0;
      r_h     <= '0;
      r_f     <= '0;
      r_c     <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_p     <= w_p_n;
      r_l     <= w_l_n;
      r_m     <= w_m_n;
      r_h     <= w_h_n;
      r_f     <= w_f_n;
      r_c     <= w_c_n;
      r_hit   <= w_hit_n;
    end
  end
  assign uo_out  = {5'(r_c), &r_c, r_state != UNCFG, r_hit};
  assign uio_out = '0;
  assign uio_oe  = '0;
endmodule

// File: tb/tb_tt_um_marxkar_progseqdet.sv
// tb_tt_um_marxkar_progseqdet: directed scoreboard bench for the programmable sequence detector
module tb_tt_um_marxkar_progseqdet;
  logic       clk = 0, rst_n = 0, ena = 1;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int         checks = 0, errors = 0, ec = 0;
  logic       ea = 0;
  logic [7:0] q[$];
  tt_um_marxkar_progseqdet dut (.ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
                                .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n));
  always #5 clk = ~clk;
  function automatic logic [7:0] mk(logic d, logic s, logic m, logic c, logic [2:0] lm1, logic cfg);
    return {cfg, lm1, c, m, s, d};
  endfunction
  task automatic drive(input logic [7:0] ui, input logic [7:0] pv, input logic eh_in, input string tag);
    logic [7:0] e;
    logic eh;
    eh = eh_in;
    ui_in = ui;
    uio_in = pv;
    if (!rst_n) begin ec = 0; ea = 0; eh = 0; end
    else if (!ena) eh = 0;
    else if (ui[7]) begin ea = 1; eh = 0; end
    else if (ui[3]) ec = 0;
    else if (eh && ec < 31) ec++;
    q.push_back({5'(ec), ec == 31, ea, eh});
    @(posedge clk);
    #1;
    e = q.pop_front();
    checks++;
    assert (uo_out === e) else begin
      errors++;
      $error("FAIL %s: uo_out=%b expected %b", tag, uo_out, e);
    end
  endtask
  task automatic bt(input logic d, input logic eh, input string tag);
    drive(mk(d, 1, 0, 0, 0, 0), 8'h00, eh, tag);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [2:0] lm1, input logic m, input logic s, input logic d);
    drive(mk(d, s, m, 0, lm1, 1), p, 0, "cfg");
  endtask
  task automatic clr();
    drive(mk(0, 0, 0, 1, 0, 0), 8'h00, 0, "clear");
  endtask
  task automatic seq(input logic [15:0] bits, input logic [15:0] hits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) bt(bits[i], hits[i], tag);
  endtask
  initial begin
    drive(mk(1, 1, 0, 0, 0, 0), 8'h00, 0, "reset");
    drive(mk(1, 1, 0, 0, 0, 0), 8'h00, 0, "reset");
    checks++;
    assert (uio_out === 8'h00 && uio_oe === 8'h00) else begin
      errors++;
      $error("FAIL uio: uio_out=%h uio_oe=%h expected 00 00", uio_out, uio_oe);
    end
    rst_n = 1;
    for (int i = 0; i < 16; i++) bt(1, 0, "uncfg");
    cfg(8'b1011, 3'd3, 0, 0, 0);
    seq(16'b1011011, 16'b0001001, 7, "overlap");
    clr();
    cfg(8'b101, 3'd2, 1, 0, 0);
    seq(16'b10101, 16'b00100, 5, "nonoverlap");
    clr();
    cfg(8'b101, 3'd2, 0, 0, 0);
    seq(16'b10101, 16'b00101, 5, "overlap3");
    clr();
    cfg(8'b1, 3'd0, 0, 0, 0);
    for (int i = 0; i < 33; i++) bt(1, 1, "saturate");
    drive(mk(1, 1, 0, 1, 0, 0), 8'h00, 1, "clear_hit");
    cfg(8'b1011, 3'd3, 0, 0, 0);
    seq(16'b101, 16'b000, 3, "gap_pre");
    for (int i = 0; i < 5; i++) drive(mk(i[0], 0, 0, 0, 0, 0), 8'h00, 0, "gap_idle");
    bt(1, 1, "gap_hit");
    cfg(8'b0110, 3'd3, 0, 1, 0);
    seq(16'b1100110, 16'b0000001, 7, "reload");
    cfg(8'b1011, 3'd3, 0, 0, 0);
    seq(16'b10, 16'b00, 2, "ena_pre");
    ena = 0;
    for (int i = 0; i < 3; i++) bt(1, 1, "ena_low");
    ena = 1;
    seq(16'b11, 16'b01, 2, "ena_resume");
    cfg(8'b1011, 3'd3, 0, 0, 0);
    seq(16'b101, 16'b000, 3, "rst_pre");
    rst_n = 0;
    bt(1, 1, "rst_mid");
    rst_n = 1;
    seq(16'b1011, 16'b0000, 4, "rst_after");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
